// File: rtl/aes_iter_encrypt.sv
// Iterative AES encryption core: one round per clock, valid/ready handshakes on both sides.
// Streams the SubBytes output of every round on thr_* while the block is in flight.
module aes_iter_encrypt #(
  parameter int KEY_BITS = 256,
  parameter int NK       = KEY_BITS / 32,
  parameter int NR       = NK + 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        pt,
  input  logic [KEY_BITS-1:0] key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        ct,
  output logic                thr_valid,
  output logic [3:0]          thr_round,
  output logic [127:0]        thr_data
);

  localparam int NW = 4 * (NR + 1);
  localparam int SW = 128 * (NR + 1);
  localparam logic [3:0] NR4 = 4'(NR);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
    $error("aes_iter_encrypt: KEY_BITS must be 128, 192 or 256");
  end

  // Forward S-box, entry 0 at the MSB end.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[8*(255-int'(b)) +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  // Byte n of the block sits at bits [127-8n -: 8]; row = n%4, column = n/4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  // Full schedule, rk[0] at the MSB end; the first NK words are the key itself.
  function automatic logic [SW-1:0] key_expansion(input logic [KEY_BITS-1:0] k);
    logic [32*NW-1:0] w;
    logic [SW-1:0]    o;
    logic [31:0]      t;
    logic [7:0]       rc;
    w  = '0;
    o  = '0;
    rc = 8'h01;
    for (int i = 0; i < NK; i++) w[32*i +: 32] = k[KEY_BITS-1-32*i -: 32];
    for (int i = NK; i < NW; i++) begin
      t = w[32*(i-1) +: 32];
      if (i % NK == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = xtime(rc);
      end else if (NK > 6 && i % NK == 4) begin
        t = sub_word(t);
      end
      w[32*i +: 32] = w[32*(i-NK) +: 32] ^ t;
    end
    for (int i = 0; i < NW; i++) o[SW-1-32*i -: 32] = w[32*i +: 32];
    return o;
  endfunction

  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} fsm_t;

  fsm_t         fsm_reg, fsm_next;
  logic [3:0]   round_reg;
  logic [127:0] state_reg;
  logic [127:0] ct_reg;
  logic         out_valid_reg;
  logic         ready_en_reg;
  logic [127:0] rk_reg      [NR+1];
  logic [127:0] sched_words [NR+1];
  logic [SW-1:0] sched_next;

  logic         accept;
  logic         last_round;
  logic [127:0] sb_out, sr_out, round_out, rk_cur;

  assign sched_next = key_expansion(key);

  genvar gi;
  generate
    for (gi = 0; gi <= NR; gi++) begin : g_sched
      assign sched_words[gi] = sched_next[SW-1-128*gi -: 128];
    end
  endgenerate

  assign rk_cur     = rk_reg[round_reg];
  assign last_round = (round_reg == NR4);
  assign sb_out     = sub_bytes(state_reg);
  assign sr_out     = shift_rows(sb_out);
  assign round_out  = last_round ? (sr_out ^ rk_cur) : (mix_columns(sr_out) ^ rk_cur);

  // ready_en_reg keeps in_ready low until the first edge after reset release.
  assign in_ready = ready_en_reg & ((fsm_reg == IDLE) | ((fsm_reg == DONE) & out_ready));
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm_reg <= IDLE;
    else     fsm_reg <= fsm_next;
  end

  always_comb begin
    fsm_next  = fsm_reg;
    thr_valid = 1'b0;
    thr_round = 4'd0;
    thr_data  = '0;
    case (fsm_reg)
      IDLE: begin
        if (accept) fsm_next = ROUND;
      end
      ROUND: begin
        thr_valid = 1'b1;
        thr_round = round_reg;
        thr_data  = sb_out;
        if (last_round) fsm_next = DONE;
      end
      DONE: begin
        if (accept)         fsm_next = ROUND;
        else if (out_ready) fsm_next = IDLE;
      end
      default: fsm_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      round_reg     <= 4'd0;
      state_reg     <= '0;
      ct_reg        <= '0;
      out_valid_reg <= 1'b0;
      ready_en_reg  <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
      if (accept) begin
        state_reg <= pt ^ sched_words[0];
        round_reg <= 4'd1;
      end else if (fsm_reg == ROUND) begin
        state_reg <= round_out;
        round_reg <= last_round ? 4'd0 : round_reg + 4'd1;
      end
      if (fsm_reg == ROUND && last_round) begin
        ct_reg        <= round_out;
        out_valid_reg <= 1'b1;
      end else if (fsm_reg == DONE && out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) rk_reg <= sched_words;
  end

  assign out_valid = out_valid_reg;
  assign ct        = ct_reg;

endmodule

// File: tb/tb_aes_iter_encrypt.sv
// Bench for aes_iter_encrypt: byte-level AES reference model, FIPS-197 vectors and random blocks
// across 256/128/192-bit instances.
module tb_aes_iter_encrypt;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, iv_s, out_ready;
  logic [127:0] pt;
  logic [255:0] key;

  logic rdy_a, ov_a, tv_a, rdy_b, ov_b, tv_b, rdy_c, ov_c, tv_c;
  logic [3:0]   tr_a, tr_b, tr_c;
  logic [127:0] ct_a, td_a, ct_b, td_b, ct_c, td_c;

  int total = 0;
  int bad   = 0;

  logic [7:0]   sb     [256];
  logic [127:0] m_thr  [15];
  int           cap_n;
  logic [3:0]   cap_round [16];
  logic [127:0] cap_data  [16];

  localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KAT_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  always #5 clk = ~clk;

  aes_iter_encrypt #(.KEY_BITS(256)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a), .pt(pt), .key(key),
    .out_valid(ov_a), .out_ready(out_ready), .ct(ct_a),
    .thr_valid(tv_a), .thr_round(tr_a), .thr_data(td_a));

  aes_iter_encrypt #(.KEY_BITS(128)) dut_b (
    .clk(clk), .rst(rst), .in_valid(iv_s), .in_ready(rdy_b), .pt(pt), .key(key[255:128]),
    .out_valid(ov_b), .out_ready(out_ready), .ct(ct_b),
    .thr_valid(tv_b), .thr_round(tr_b), .thr_data(td_b));

  aes_iter_encrypt #(.KEY_BITS(192)) dut_c (
    .clk(clk), .rst(rst), .in_valid(iv_s), .in_ready(rdy_c), .pt(pt), .key(key[255:64]),
    .out_valid(ov_c), .out_ready(out_ready), .ct(ct_c),
    .thr_valid(tv_c), .thr_round(tr_c), .thr_data(td_c));

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic init_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_encrypt(input logic [255:0] k, input int nk, input logic [127:0] p,
                               output logic [127:0] c);
    int nr;
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc, a0, a1, a2, a3;
    logic [7:0]  s [16];
    logic [7:0]  u [16];
    nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        rc = 8'h01;
        for (int j = 1; j < i / nk; j++) rc = gmul(rc, 8'h02);
        t[31:24] ^= rc;
      end else if (nk > 6 && i % nk == 4) begin
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int j = 0; j < 16; j++) s[j] = p[127-8*j -: 8] ^ w[j/4][31-8*(j%4) -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int j = 0; j < 16; j++) s[j] = sb[s[j]];
      for (int j = 0; j < 16; j++) m_thr[r][127-8*j -: 8] = s[j];
      for (int row = 0; row < 4; row++)
        for (int col = 0; col < 4; col++)
          u[row+4*col] = s[row+4*((col+row)%4)];
      for (int col = 0; col < 4; col++) begin
        a0 = u[4*col]; a1 = u[4*col+1]; a2 = u[4*col+2]; a3 = u[4*col+3];
        if (r < nr) begin
          s[4*col]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*col+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*col+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*col+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[4*col] = a0; s[4*col+1] = a1; s[4*col+2] = a2; s[4*col+3] = a3;
        end
      end
      for (int j = 0; j < 16; j++) s[j] ^= w[4*r + j/4][31-8*(j%4) -: 8];
    end
    for (int j = 0; j < 16; j++) c[127-8*j -: 8] = s[j];
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [255:0] rand256();
    return {rand128(), rand128()};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one block to the 256-bit instance and records every thr strobe until out_valid.
  task automatic send_and_wait(input logic [127:0] p, input logic [255:0] k, input bit toggle,
                               output int lat);
    int n;
    pt = p; key = k; in_valid = 1'b1; n = 0;
    while (rdy_a !== 1'b1 && n < 50) begin tick(); n++; end
    tick();
    if (!toggle) in_valid = 1'b0;
    cap_n = 0; lat = 0;
    while (ov_a !== 1'b1 && lat < 40) begin
      if (tv_a === 1'b1 && cap_n < 16) begin
        cap_round[cap_n] = tr_a; cap_data[cap_n] = td_a; cap_n++;
      end
      if (toggle) begin pt = rand128(); key = rand256(); end
      tick(); lat++;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; iv_s = 1'b0; out_ready = 1'b0; pt = '0; key = '0;
    tick(); tick();
    total++;
    if (rdy_a !== 1'b0 || ov_a !== 1'b0 || tv_a !== 1'b0) begin
      bad++; $display("FAIL reset_flags: in_ready=%b out_valid=%b thr_valid=%b want 0 0 0", rdy_a, ov_a, tv_a);
    end
    total++;
    if (ct_a !== '0 || td_a !== '0 || tr_a !== 4'd0) begin
      bad++; $display("FAIL reset_data: ct=%h thr_data=%h thr_round=%0d want zeros", ct_a, td_a, tr_a);
    end
    rst = 1'b0;
    #1;
    total++;
    if (rdy_a !== 1'b0) begin bad++; $display("FAIL reset_release_ready: in_ready=%b want 0", rdy_a); end
    tick();
    total++;
    if (rdy_a !== 1'b1) begin bad++; $display("FAIL reset_first_edge_ready: in_ready=%b want 1", rdy_a); end
    $display("test_reset: checks done");
  endtask

  task automatic test_kat256();
    logic [127:0] exp;
    int lat;
    out_ready = 1'b0;
    model_encrypt(KAT_KEY, 8, KAT_PT, exp);
    send_and_wait(KAT_PT, KAT_KEY, 1'b0, lat);
    total++;
    if (lat != 14) begin bad++; $display("FAIL kat256_latency: got %0d want 14", lat); end
    total++;
    if (ct_a !== 128'h8ea2b7ca516745bfeafc49904b496089) begin
      bad++; $display("FAIL kat256_fips_ct: got %h want 8ea2b7ca516745bfeafc49904b496089", ct_a);
    end
    total++;
    if (ct_a !== exp) begin bad++; $display("FAIL kat256_model_ct: got %h want %h", ct_a, exp); end
    total++;
    if (cap_n != 14) begin bad++; $display("FAIL kat256_thr_count: got %0d want 14", cap_n); end
    for (int i = 0; i < 14; i++) begin
      total++;
      if (cap_round[i] !== 4'(i+1) || cap_data[i] !== m_thr[i+1]) begin
        bad++; $display("FAIL kat256_thr[%0d]: round=%0d data=%h want round=%0d data=%h",
                        i, cap_round[i], cap_data[i], i+1, m_thr[i+1]);
      end
    end
    $display("test_kat256: ct=%h latency=%0d strobes=%0d", ct_a, lat, cap_n);
    drain();
  endtask

  task automatic test_kat_small();
    logic [127:0] exp_b, exp_c;
    logic [127:0] thr_b [15];
    logic [127:0] thr_c [15];
    int lat_b, lat_c, nb, nc, n;
    out_ready = 1'b0;
    model_encrypt(KAT_KEY, 4, KAT_PT, exp_b);
    for (int i = 1; i <= 10; i++) thr_b[i] = m_thr[i];
    model_encrypt(KAT_KEY, 6, KAT_PT, exp_c);
    for (int i = 1; i <= 12; i++) thr_c[i] = m_thr[i];
    pt = KAT_PT; key = KAT_KEY; iv_s = 1'b1; n = 0;
    while ((rdy_b !== 1'b1 || rdy_c !== 1'b1) && n < 50) begin tick(); n++; end
    tick();
    iv_s = 1'b0;
    lat_b = -1; lat_c = -1; nb = 0; nc = 0;
    for (int e = 0; e < 30; e++) begin
      if (tv_b === 1'b1 && nb < 14) begin
        total++;
        if (tr_b !== 4'(nb+1) || td_b !== thr_b[nb+1]) begin
          bad++; $display("FAIL kat128_thr[%0d]: round=%0d data=%h want %0d %h", nb, tr_b, td_b, nb+1, thr_b[nb+1]);
        end
        nb++;
      end
      if (tv_c === 1'b1 && nc < 14) begin
        total++;
        if (tr_c !== 4'(nc+1) || td_c !== thr_c[nc+1]) begin
          bad++; $display("FAIL kat192_thr[%0d]: round=%0d data=%h want %0d %h", nc, tr_c, td_c, nc+1, thr_c[nc+1]);
        end
        nc++;
      end
      if (ov_b === 1'b1 && lat_b < 0) lat_b = e;
      if (ov_c === 1'b1 && lat_c < 0) lat_c = e;
      tick();
    end
    total++;
    if (lat_b != 10 || nb != 10) begin bad++; $display("FAIL kat128_timing: latency=%0d strobes=%0d want 10 10", lat_b, nb); end
    total++;
    if (lat_c != 12 || nc != 12) begin bad++; $display("FAIL kat192_timing: latency=%0d strobes=%0d want 12 12", lat_c, nc); end
    total++;
    if (ct_b !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a || ct_b !== exp_b) begin
      bad++; $display("FAIL kat128_ct: got %h want %h", ct_b, exp_b);
    end
    total++;
    if (ct_c !== 128'hdda97ca4864cdfe06eaf70a0ec0d7191 || ct_c !== exp_c) begin
      bad++; $display("FAIL kat192_ct: got %h want %h", ct_c, exp_c);
    end
    $display("test_kat_small: ct128=%h ct192=%h", ct_b, ct_c);
    drain();
  endtask

  task automatic test_hold();
    logic [127:0] p, exp;
    logic [255:0] k;
    int lat;
    out_ready = 1'b0;
    p = rand128(); k = rand256();
    model_encrypt(k, 8, p, exp);
    send_and_wait(p, k, 1'b0, lat);
    total++;
    if (lat != 14 || ct_a !== exp) begin bad++; $display("FAIL hold_result: latency=%0d ct=%h want 14 %h", lat, ct_a, exp); end
    in_valid = 1'b1; pt = rand128(); key = rand256();
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if (ct_a !== exp || rdy_a !== 1'b0 || tv_a !== 1'b0 || ov_a !== 1'b1) begin
        bad++; $display("FAIL hold_cycle%0d: ct=%h in_ready=%b thr_valid=%b out_valid=%b want %h 0 0 1",
                        i, ct_a, rdy_a, tv_a, ov_a, exp);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    total++;
    if (rdy_a !== 1'b1) begin bad++; $display("FAIL hold_ready_on_consume: in_ready=%b want 1", rdy_a); end
    tick();
    total++;
    if (ov_a !== 1'b0) begin bad++; $display("FAIL hold_drop: out_valid=%b want 0", ov_a); end
    out_ready = 1'b0;
    $display("test_hold: ct=%h held 20 cycles", exp);
  endtask

  task automatic test_back_to_back();
    logic [127:0] q [$];
    logic [127:0] exp;
    int acc_cyc [3];
    int acc, done, cyc;
    bit acc_now, out_now;
    out_ready = 1'b1; in_valid = 1'b1; pt = rand128(); key = rand256();
    acc = 0; done = 0; cyc = 0;
    while (done < 3 && cyc < 200) begin
      acc_now = (in_valid === 1'b1 && rdy_a === 1'b1);
      out_now = (ov_a === 1'b1);
      if (acc_now) begin
        model_encrypt(key, 8, pt, exp);
        q.push_back(exp);
        acc_cyc[acc] = cyc;
        acc++;
      end
      if (out_now) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL b2b_unexpected_out: ct=%h with nothing pending", ct_a);
        end else begin
          exp = q.pop_front();
          if (ct_a !== exp) begin bad++; $display("FAIL b2b_ct%0d: got %h want %h", done, ct_a, exp); end
          else $display("b2b block %0d: ct=%h", done, ct_a);
        end
        done++;
      end
      tick(); cyc++;
      if (acc_now) begin
        if (acc == 3) in_valid = 1'b0;
        else begin pt = rand128(); key = rand256(); end
      end
    end
    total++;
    if (done != 3 || acc != 3) begin bad++; $display("FAIL b2b_count: accepted=%0d done=%0d want 3 3", acc, done); end
    else begin
      total++;
      if (acc_cyc[1] - acc_cyc[0] != 15 || acc_cyc[2] - acc_cyc[1] != 15) begin
        bad++; $display("FAIL b2b_spacing: %0d %0d want 15 15", acc_cyc[1]-acc_cyc[0], acc_cyc[2]-acc_cyc[1]);
      end
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_toggle();
    logic [127:0] p, exp;
    logic [255:0] k;
    int lat;
    out_ready = 1'b0;
    p = rand128(); k = rand256();
    model_encrypt(k, 8, p, exp);
    send_and_wait(p, k, 1'b1, lat);
    total++;
    if (lat != 14) begin bad++; $display("FAIL toggle_latency: got %0d want 14", lat); end
    total++;
    if (ct_a !== exp) begin bad++; $display("FAIL toggle_ct: got %h want %h", ct_a, exp); end
    $display("test_toggle: ct=%h", ct_a);
    drain();
  endtask

  task automatic test_reset_mid();
    logic [127:0] p, exp;
    logic [255:0] k;
    int lat, n, stray;
    out_ready = 1'b0;
    pt = rand128(); key = rand256(); in_valid = 1'b1; n = 0;
    while (rdy_a !== 1'b1 && n < 50) begin tick(); n++; end
    tick();
    in_valid = 1'b0; n = 0;
    while (tr_a !== 4'd7 && n < 20) begin tick(); n++; end
    total++;
    if (n >= 20) begin bad++; $display("FAIL midrst_reach_round7: thr_round=%0d want 7", tr_a); end
    rst = 1'b1;
    #1;
    total++;
    if (ov_a !== 1'b0 || tv_a !== 1'b0 || tr_a !== 4'd0 || ct_a !== '0 || td_a !== '0 || rdy_a !== 1'b0) begin
      bad++; $display("FAIL midrst_outputs: out_valid=%b thr_valid=%b thr_round=%0d ct=%h thr_data=%h in_ready=%b want zeros",
                      ov_a, tv_a, tr_a, ct_a, td_a, rdy_a);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    total++;
    if (rdy_a !== 1'b1) begin bad++; $display("FAIL midrst_ready: in_ready=%b want 1", rdy_a); end
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      if (ov_a !== 1'b0 || tv_a !== 1'b0) stray++;
      tick();
    end
    total++;
    if (stray != 0) begin bad++; $display("FAIL midrst_stray: %0d cycles with out_valid/thr_valid want 0", stray); end
    p = rand128(); k = rand256();
    model_encrypt(k, 8, p, exp);
    send_and_wait(p, k, 1'b0, lat);
    total++;
    if (lat != 14 || ct_a !== exp) begin bad++; $display("FAIL midrst_next_block: latency=%0d ct=%h want 14 %h", lat, ct_a, exp); end
    $display("test_reset_mid: next ct=%h", ct_a);
    drain();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    init_sbox();
    test_reset();
    test_kat256();
    test_kat_small();
    test_hold();
    test_back_to_back();
    test_toggle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
